// File: rtl/rx_decoder.sv
// USB full-speed receive front end: NRZI decode, bit unstuffing, SYNC/PID
// recognition, byte assembly and EOP detection for the packet-reception FSM.
module rx_decoder (
  input  logic       clk,
  input  logic       nRST,
  input  logic       bit_strobe,
  input  logic       dp,
  input  logic       dm,
  output logic       byte_valid,
  output logic [7:0] rx_data,
  output logic       is_sync,
  output logic [3:0] pid,
  output logic       pid_valid,
  output logic       rx_eop,
  output logic       rx_err,
  output logic       rx_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_ERROR
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_prev_k, w_prev_k_nxt;   // last J/K line state, 1 = K
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [2:0] r_ones, w_ones_nxt;
  logic       r_se0, w_se0_nxt;
  logic [2:0] r_jcnt, w_jcnt_nxt;
  logic       r_byte_valid, w_byte_valid_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_is_sync, w_is_sync_nxt;
  logic [3:0] r_pid, w_pid_nxt;
  logic       r_pid_valid, w_pid_valid_nxt;
  logic       r_rx_eop, w_rx_eop_nxt;
  logic       r_rx_err, w_rx_err_nxt;
  logic       r_rx_active, w_rx_active_nxt;

  logic       w_is_j, w_is_k, w_is_se0, w_is_se1, w_bit, w_err;
  logic [7:0] w_shift_in;
  logic [2:0] w_ones_inc;

  assign w_is_j     = (dp == 1'b1) && (dm == 1'b0);
  assign w_is_k     = (dp == 1'b0) && (dm == 1'b1);
  assign w_is_se0   = (dp == 1'b0) && (dm == 1'b0);
  assign w_is_se1   = (dp == 1'b1) && (dm == 1'b1);
  assign w_bit      = w_is_k ~^ r_prev_k;
  assign w_shift_in = {w_bit, r_shift[7:1]};
  assign w_ones_inc = (r_ones == 3'd6) ? 3'd6 : r_ones + 3'd1;

  // NOTE: every variable gets its hold/idle value first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_k_nxt     = r_prev_k;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_ones_nxt       = r_ones;
    w_se0_nxt        = r_se0;
    w_jcnt_nxt       = r_jcnt;
    w_byte_valid_nxt = 1'b0;
    w_rx_data_nxt    = r_rx_data;
    w_is_sync_nxt    = 1'b0;
    w_pid_nxt        = r_pid;
    w_pid_valid_nxt  = 1'b0;
    w_rx_eop_nxt     = 1'b0;
    w_rx_err_nxt     = 1'b0;
    w_rx_active_nxt  = r_rx_active;
    w_err            = 1'b0;

    if (bit_strobe) begin
      if (w_is_j || w_is_k) w_prev_k_nxt = w_is_k;
      case (r_state)
        S_IDLE: begin
          if (w_is_k) begin
            w_state_nxt     = S_SYNC;
            w_rx_active_nxt = 1'b1;
            w_shift_nxt     = w_shift_in;
            w_bit_cnt_nxt   = 3'd1;
            w_ones_nxt      = 3'd0;
            w_se0_nxt       = 1'b0;
          end
        end
        S_SYNC: begin
          if (w_is_j || w_is_k) begin
            w_shift_nxt   = w_shift_in;
            w_ones_nxt    = w_bit ? w_ones_inc : 3'd0;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (w_shift_in == 8'h80) begin
                w_byte_valid_nxt = 1'b1;
                w_is_sync_nxt    = 1'b1;
                w_rx_data_nxt    = 8'h80;
                w_state_nxt      = S_PID;
              end else begin
                w_err = 1'b1;
              end
            end
          end else begin
            w_err = 1'b1;
          end
        end
        S_PID, S_DATA: begin
          if (w_is_se1) begin
            w_err = 1'b1;
          end else if (w_is_se0) begin
            w_se0_nxt = 1'b1;
          end else if (r_se0) begin
            if (w_is_j) begin
              // Leftover dribble bits in the shifter are simply dropped here.
              w_byte_valid_nxt = 1'b1;
              w_rx_eop_nxt     = 1'b1;
              w_rx_data_nxt    = 8'h00;
              w_rx_active_nxt  = 1'b0;
              w_state_nxt      = S_IDLE;
              w_se0_nxt        = 1'b0;
              w_bit_cnt_nxt    = 3'd0;
              w_ones_nxt       = 3'd0;
            end else begin
              w_err = 1'b1;
            end
          end else if (r_ones == 3'd6) begin
            if (w_bit) w_err = 1'b1;
            else       w_ones_nxt = 3'd0;
          end else begin
            w_ones_nxt    = w_bit ? w_ones_inc : 3'd0;
            w_shift_nxt   = w_shift_in;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_state == S_DATA) begin
                w_byte_valid_nxt = 1'b1;
                w_rx_data_nxt    = w_shift_in;
              end else if (w_shift_in[7:4] == ~w_shift_in[3:0]) begin
                w_byte_valid_nxt = 1'b1;
                w_pid_valid_nxt  = 1'b1;
                w_pid_nxt        = w_shift_in[3:0];
                w_rx_data_nxt    = w_shift_in;
                w_state_nxt      = S_DATA;
              end else begin
                w_err = 1'b1;
              end
            end
          end
        end
        S_ERROR: begin
          if (w_is_j) begin
            if (r_se0 || (r_jcnt == 3'd7)) begin
              w_state_nxt     = S_IDLE;
              w_rx_active_nxt = 1'b0;
              w_jcnt_nxt      = 3'd0;
            end else begin
              w_jcnt_nxt = r_jcnt + 3'd1;
            end
            w_se0_nxt = 1'b0;
          end else if (w_is_se0) begin
            w_se0_nxt  = 1'b1;
            w_jcnt_nxt = 3'd0;
          end else begin
            w_se0_nxt  = 1'b0;
            w_jcnt_nxt = 3'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_err) begin
        w_state_nxt  = S_ERROR;
        w_rx_err_nxt = 1'b1;
        w_se0_nxt    = 1'b0;
        w_jcnt_nxt   = 3'd0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_prev_k     <= 1'b0;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_ones       <= 3'd0;
      r_se0        <= 1'b0;
      r_jcnt       <= 3'd0;
      r_byte_valid <= 1'b0;
      r_rx_data    <= 8'h00;
      r_is_sync    <= 1'b0;
      r_pid        <= 4'h0;
      r_pid_valid  <= 1'b0;
      r_rx_eop     <= 1'b0;
      r_rx_err     <= 1'b0;
      r_rx_active  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_k     <= w_prev_k_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_ones       <= w_ones_nxt;
      r_se0        <= w_se0_nxt;
      r_jcnt       <= w_jcnt_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_is_sync    <= w_is_sync_nxt;
      r_pid        <= w_pid_nxt;
      r_pid_valid  <= w_pid_valid_nxt;
      r_rx_eop     <= w_rx_eop_nxt;
      r_rx_err     <= w_rx_err_nxt;
      r_rx_active  <= w_rx_active_nxt;
    end
  end

  assign byte_valid = r_byte_valid;
  assign rx_data    = r_rx_data;
  assign is_sync    = r_is_sync;
  assign pid        = r_pid;
  assign pid_valid  = r_pid_valid;
  assign rx_eop     = r_rx_eop;
  assign rx_err     = r_rx_err;
  assign rx_active  = r_rx_active;

endmodule

// File: tb/tb_rx_decoder.sv
// Directed bench for rx_decoder: line symbols come from a small NRZI/stuffing
// encoder; every byte_valid is logged and compared against hand-computed records.
module tb_rx_decoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [1:0] LSE1 = 2'b11;

  logic       clk = 1'b0;
  logic       nRST;
  logic       bit_strobe;
  logic       dp;
  logic       dm;
  logic       byte_valid;
  logic [7:0] rx_data;
  logic       is_sync;
  logic [3:0] pid;
  logic       pid_valid;
  logic       rx_eop;
  logic       rx_err;
  logic       rx_active;

  rx_decoder dut (
    .clk        (clk),
    .nRST       (nRST),
    .bit_strobe (bit_strobe),
    .dp         (dp),
    .dm         (dm),
    .byte_valid (byte_valid),
    .rx_data    (rx_data),
    .is_sync    (is_sync),
    .pid        (pid),
    .pid_valid  (pid_valid),
    .rx_eop     (rx_eop),
    .rx_err     (rx_err),
    .rx_active  (rx_active)
  );

  always #5 clk = ~clk;

  // Record layout: {rx_data, 0, is_sync, pid_valid, rx_eop, pid}
  logic [15:0] mon_q[$];
  int          err_pulses = 0;
  int          bv_run     = 0;
  int          bv_max     = 0;

  always @(negedge clk) begin
    if (byte_valid) begin
      mon_q.push_back({rx_data, 1'b0, is_sync, pid_valid, rx_eop, pid});
      bv_run <= bv_run + 1;
      if (bv_run + 1 > bv_max) bv_max <= bv_run + 1;
    end else begin
      bv_run <= 0;
    end
    if (rx_err) err_pulses <= err_pulses + 1;
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] cur;
  int         ones;
  logic       b2b;
  logic       stuff_one;
  int         qb;
  int         eb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rec(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] obs;
    obs = (idx < mon_q.size()) ? mon_q[idx] : 16'hxxxx;
    check(tag, {16'h0, obs}, {16'h0, exp});
  endtask

  task automatic sym(input logic [1:0] ln);
    @(negedge clk);
    {dp, dm}   = ln;
    bit_strobe = 1'b1;
    if (!b2b) begin
      @(negedge clk);
      bit_strobe = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bit_strobe = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tx_bit(input logic b);
    if (!b) cur = (cur == LJ) ? LK : LJ;
    sym(cur);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      if (!stuff_one) cur = (cur == LJ) ? LK : LJ;
      sym(cur);
      ones = stuff_one ? 7 : 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bit(b[i]);
  endtask

  task automatic tx_sync();
    cur  = LJ;
    ones = 0;
    for (int i = 0; i < 7; i++) tx_bit(1'b0);
    tx_bit(1'b1);
  endtask

  task automatic tx_eop(input int n_se0);
    repeat (n_se0) sym(LSE0);
    sym(LJ);
    cur = LJ;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; bit_strobe = 1'b0; dp = 1'b1; dm = 1'b0;
    b2b = 1'b0; stuff_one = 1'b0; cur = LJ; ones = 0;
    repeat (3) @(negedge clk);
    check("reset_byte_valid", {31'h0, byte_valid}, 32'h0);
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_flags", {28'h0, is_sync, pid_valid, rx_eop, rx_err}, 32'h0);
    check("reset_pid", {28'h0, pid}, 32'h0);
    check("reset_rx_active", {31'h0, rx_active}, 32'h0);
    nRST = 1'b1;

    // Idle line noise: J, SE0 and SE1 never start a packet
    qb = mon_q.size(); eb = err_pulses;
    sym(LJ); sym(LSE0); sym(LSE1); sym(LJ);
    idle(2);
    check("idle_rx_active", {31'h0, rx_active}, 32'h0);
    check("idle_no_bytes", mon_q.size() - qb, 0);
    check("idle_no_err", err_pulses - eb, 0);

    // IN token: SYNC, 0x69, 0x85, 0x18, SE0 x2, J
    qb = mon_q.size(); eb = err_pulses;
    tx_sync();
    check("in_active", {31'h0, rx_active}, 32'h1);
    tx_byte(8'h69); tx_byte(8'h85); tx_byte(8'h18);
    tx_eop(2);
    check("in_eop_inactive", {31'h0, rx_active}, 32'h0);
    idle(3);
    check("in_count", mon_q.size() - qb, 5);
    rec("in_sync", qb + 0, 16'h8040);
    rec("in_pid", qb + 1, 16'h6929);
    rec("in_b0", qb + 2, 16'h8509);
    rec("in_b1", qb + 3, 16'h1809);
    rec("in_eop", qb + 4, 16'h0019);
    check("in_no_err", err_pulses - eb, 0);
    check("in_rx_data_held", {24'h0, rx_data}, 32'h0);

    // DATA0 with a stuffed zero inside the 0xFF run
    qb = mon_q.size(); eb = err_pulses;
    tx_sync(); tx_byte(8'hC3); tx_byte(8'hFF); tx_byte(8'h00);
    tx_eop(2);
    idle(3);
    check("stuff_count", mon_q.size() - qb, 5);
    rec("stuff_sync", qb + 0, 16'h8049);
    rec("stuff_pid", qb + 1, 16'hC323);
    rec("stuff_ff", qb + 2, 16'hFF03);
    rec("stuff_00", qb + 3, 16'h0003);
    rec("stuff_eop", qb + 4, 16'h0013);
    check("stuff_no_err", err_pulses - eb, 0);

    // Stuff bit driven as 1, then leave ERROR with 8 consecutive J
    qb = mon_q.size(); eb = err_pulses;
    stuff_one = 1'b1;
    tx_sync(); tx_byte(8'hC3); tx_byte(8'hFF);
    stuff_one = 1'b0;
    for (int i = 0; i < 7; i++) sym(LJ);
    check("stufferr_active_7j", {31'h0, rx_active}, 32'h1);
    sym(LJ);
    check("stufferr_exit_8j", {31'h0, rx_active}, 32'h0);
    cur = LJ;
    idle(3);
    check("stufferr_count", mon_q.size() - qb, 2);
    rec("stufferr_sync", qb + 0, 16'h8043);
    rec("stufferr_pid", qb + 1, 16'hC323);
    check("stufferr_err_pulses", err_pulses - eb, 1);

    // Bad PID 0x6A, exit via SE0 then J, then a clean DATA1 packet
    qb = mon_q.size(); eb = err_pulses;
    tx_sync(); tx_byte(8'h6A);
    idle(2);
    check("badpid_pid_held", {28'h0, pid}, 32'h3);
    check("badpid_err_pulses", err_pulses - eb, 1);
    sym(LSE0);
    check("badpid_active_se0", {31'h0, rx_active}, 32'h1);
    sym(LJ);
    check("badpid_exit", {31'h0, rx_active}, 32'h0);
    tx_sync(); tx_byte(8'h4B);
    tx_eop(1);
    idle(3);
    check("badpid_count", mon_q.size() - qb, 4);
    rec("badpid_sync", qb + 0, 16'h8043);
    rec("clean_sync", qb + 1, 16'h8043);
    rec("clean_pid", qb + 2, 16'h4B2B);
    rec("clean_eop", qb + 3, 16'h001B);
    check("badpid_total_err", err_pulses - eb, 1);

    // Dribble bits and a three-sample SE0
    qb = mon_q.size(); eb = err_pulses;
    tx_sync(); tx_byte(8'hC3); tx_byte(8'h5A);
    tx_bit(1'b1); tx_bit(1'b0); tx_bit(1'b1);
    tx_eop(3);
    idle(3);
    check("dribble_count", mon_q.size() - qb, 4);
    rec("dribble_sync", qb + 0, 16'h804B);
    rec("dribble_pid", qb + 1, 16'hC323);
    rec("dribble_5a", qb + 2, 16'h5A03);
    rec("dribble_eop", qb + 3, 16'h0013);
    check("dribble_no_err", err_pulses - eb, 0);

    // ACK with bit_strobe held high for the whole packet
    qb = mon_q.size(); eb = err_pulses;
    b2b = 1'b1;
    tx_sync(); tx_byte(8'hD2); tx_eop(2);
    b2b = 1'b0;
    idle(3);
    check("b2b_count", mon_q.size() - qb, 3);
    rec("b2b_sync", qb + 0, 16'h8043);
    rec("b2b_pid", qb + 1, 16'hD222);
    rec("b2b_eop", qb + 2, 16'h0012);
    check("b2b_no_err", err_pulses - eb, 0);
    check("b2b_rx_active", {31'h0, rx_active}, 32'h0);

    // Asynchronous reset after 4 payload bits; line left at K
    qb = mon_q.size(); eb = err_pulses;
    tx_sync(); tx_byte(8'hC3);
    tx_bit(1'b0); tx_bit(1'b0); tx_bit(1'b1); tx_bit(1'b1);
    check("rst_pre_active", {31'h0, rx_active}, 32'h1);
    check("rst_pre_data", {24'h0, rx_data}, 32'hC3);
    #2 nRST = 1'b0;
    #1;
    check("rst_now_active", {31'h0, rx_active}, 32'h0);
    check("rst_now_data", {24'h0, rx_data}, 32'h0);
    check("rst_now_pid", {28'h0, pid}, 32'h0);
    check("rst_now_strobes", {28'h0, byte_valid, is_sync, pid_valid, rx_err}, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    tx_sync(); tx_byte(8'h69); tx_byte(8'h85);
    tx_eop(2);
    idle(3);
    check("rst_count", mon_q.size() - qb, 6);
    rec("rst_old_sync", qb + 0, 16'h8042);
    rec("rst_old_pid", qb + 1, 16'hC323);
    rec("rst_new_sync", qb + 2, 16'h8040);
    rec("rst_new_pid", qb + 3, 16'h6929);
    rec("rst_new_b0", qb + 4, 16'h8509);
    rec("rst_new_eop", qb + 5, 16'h0019);
    check("rst_no_err", err_pulses - eb, 0);

    check("byte_valid_max_run", bv_max, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
